// File: rtl/risc_fetch_queue_if.sv
// Fetch-queue bus: instruction-memory request/response, redirect and decode dequeue.
interface risc_fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [29:0]   IADDR;
  logic          IREQ;
  logic [31:0]   INSTR;
  logic          REDIRECT;
  logic [31:0]   REDIRECT_PC;
  logic          DEQ_VALID;
  logic          DEQ_READY;
  logic [31:0]   DEQ_INSTR;
  logic [31:0]   DEQ_PCADD4;
  logic [CW-1:0] COUNT;

  // Fetch unit side
  modport master (
    output IADDR, IREQ, DEQ_VALID, DEQ_INSTR, DEQ_PCADD4, COUNT,
    input  INSTR, REDIRECT, REDIRECT_PC, DEQ_READY
  );

  // Environment side: memory, ID-stage redirect and decode
  modport slave (
    input  IADDR, IREQ, DEQ_VALID, DEQ_INSTR, DEQ_PCADD4, COUNT,
    output INSTR, REDIRECT, REDIRECT_PC, DEQ_READY
  );
endinterface

// File: rtl/risc_fetch_queue.sv
// risc_fetch_queue: PC generator, fixed-latency instruction-memory delay line and
// DEPTH-entry prefetch FIFO with credit-based issue and one-cycle redirect flush.
module risc_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          MEM_LAT  = 1,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               CLK,
  input  logic               RST,
  risc_fetch_queue_if.master bus
);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);
  // Wide enough for COUNT + inflight + 1 without overflow
  localparam int CRW = $clog2(DEPTH + MEM_LAT + 2) + 1;

  logic [31:0]        pc_q, pc_d, pc_plus4;
  logic [MEM_LAT-1:0] lat_vld_q, lat_vld_d;
  logic [31:0]        lat_pc4_q [MEM_LAT];
  logic [31:0]        lat_pc4_d [MEM_LAT];
  logic [31:0]        fifo_instr_mem [DEPTH];
  logic [31:0]        fifo_pc4_mem [DEPTH];
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [CRW-1:0]     inflight;
  logic               flush, deq_valid, deq_fire, issue, wr_en;
  logic [1:0]         unused_rpc_bits;

  // Low address bits of a redirect target are forced to zero
  assign unused_rpc_bits = bus.REDIRECT_PC[1:0];

  // Handshake, credit check and next-state for PC, pointers and occupancy
  always_comb begin
    flush    = RST | bus.REDIRECT;
    inflight = '0;
    for (int i = 0; i < MEM_LAT; i++) begin
      inflight = inflight + CRW'(lat_vld_q[i]);
    end
    deq_valid = (count_q != '0) & ~flush;
    deq_fire  = deq_valid & bus.DEQ_READY;
    // A slot freed by this cycle's dequeue may be reused by this cycle's issue
    issue     = ~flush & ((CRW'(count_q) + inflight) < (CRW'(DEPTH) + CRW'(deq_fire)));
    // Responses whose delay-line slot was cleared by a flush are simply dropped
    wr_en     = lat_vld_q[MEM_LAT-1] & ~flush;
    pc_plus4  = pc_q + 32'd4;

    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.REDIRECT) begin
      pc_d     = {bus.REDIRECT_PC[31:2], 2'b00};
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (issue)    pc_d     = pc_plus4;
      if (wr_en)    wr_ptr_d = wr_ptr_q + AW'(1);
      if (deq_fire) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_en, deq_fire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Delay line: stage 0 takes the new request, each later stage copies its predecessor
  always_comb begin
    for (int i = MEM_LAT - 1; i > 0; i--) begin
      lat_vld_d[i] = lat_vld_q[i-1];
      lat_pc4_d[i] = lat_pc4_q[i-1];
    end
    lat_vld_d[0] = issue;
    lat_pc4_d[0] = pc_plus4;
    if (flush) lat_vld_d = '0;
  end

  // Control state register with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q      <= RESET_PC;
      lat_vld_q <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      pc_q      <= pc_d;
      lat_vld_q <= lat_vld_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
    end
  end

  // Delay-line payload; meaningful only where the matching valid bit is set
  always_ff @(posedge CLK) begin
    lat_pc4_q <= lat_pc4_d;
  end

  // FIFO storage: response data and its PC+4 written at the write pointer
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      fifo_instr_mem[wr_ptr_q] <= bus.INSTR;
      fifo_pc4_mem[wr_ptr_q]   <= lat_pc4_q[MEM_LAT-1];
    end
  end

  assign bus.IADDR      = pc_q[31:2];
  assign bus.IREQ       = issue;
  assign bus.DEQ_VALID  = deq_valid;
  assign bus.DEQ_INSTR  = fifo_instr_mem[rd_ptr_q];
  assign bus.DEQ_PCADD4 = fifo_pc4_mem[rd_ptr_q];
  assign bus.COUNT      = count_q;

  // The credit scheme must never let a response land in a full FIFO
  a_no_overflow: assert property (@(posedge CLK) disable iff (RST)
    !(wr_en && (count_q == CW'(DEPTH))));

endmodule

// File: tb/tb_risc_fetch_queue.sv
// Bench for risc_fetch_queue: five configurations share one directed stimulus script;
// a queue-level model predicts every output each cycle, plus hand-computed checkpoints.
module tb_risc_fetch_queue;
  localparam int NI   = 5;
  localparam int LOGN = 256;

  function automatic int cfg_depth(input int i);
    case (i)
      4:       return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int cfg_lat(input int i);
    case (i)
      0:       return 1;
      1:       return 2;
      2:       return 3;
      3:       return 1;
      default: return 3;
    endcase
  endfunction

  function automatic logic [31:0] cfg_pc(input int i);
    case (i)
      0, 1:    return 32'h0000_0100;
      2:       return 32'h0000_0000;
      3:       return 32'hFFFF_FFF8;
      default: return 32'h0000_0040;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst, redirect, rdy;
  logic [31:0] rpc;
  int          cyc;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          ireq_pulses = 0;

  logic [NI-1:0] o_ireq, o_dv;
  logic [29:0]   o_iaddr [NI];
  logic [31:0]   o_instr [NI];
  logic [31:0]   o_pc4   [NI];
  logic [31:0]   o_count [NI];

  always #5 clk = ~clk;

  // DUT instances, each with a memory that returns the byte address as data
  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    localparam int          D = cfg_depth(gi);
    localparam int          L = cfg_lat(gi);
    localparam logic [31:0] P = cfg_pc(gi);

    risc_fetch_queue_if #(.DEPTH(D)) bus ();

    logic [29:0]  mem_adr [L];
    logic [L-1:0] mem_vld = '0;

    always @(posedge clk) begin
      for (int k = L - 1; k > 0; k--) begin
        mem_vld[k] <= mem_vld[k-1];
        mem_adr[k] <= mem_adr[k-1];
      end
      mem_vld[0] <= bus.IREQ;
      mem_adr[0] <= bus.IADDR;
    end

    assign bus.INSTR       = mem_vld[L-1] ? {mem_adr[L-1], 2'b00} : 32'hDEAD_BEEF;
    assign bus.REDIRECT    = redirect;
    assign bus.REDIRECT_PC = rpc;
    assign bus.DEQ_READY   = rdy;

    risc_fetch_queue #(.DEPTH(D), .MEM_LAT(L), .RESET_PC(P)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus.master)
    );

    assign o_ireq[gi]  = bus.IREQ;
    assign o_dv[gi]    = bus.DEQ_VALID;
    assign o_iaddr[gi] = bus.IADDR;
    assign o_instr[gi] = bus.DEQ_INSTR;
    assign o_pc4[gi]   = bus.DEQ_PCADD4;
    assign o_count[gi] = 32'(bus.COUNT);
  end

  // Model: a log of issued fetches; [head, arr) is the FIFO, [arr, iss) is in flight
  logic [31:0]   m_pc [NI]  = '{default: 32'h0};
  int            m_iss [NI] = '{default: 0};
  int            m_arr [NI] = '{default: 0};
  int            m_head [NI] = '{default: 0};
  logic [31:0]   log_pc [NI][LOGN];
  int            log_cyc [NI][LOGN];
  int            tcyc = 0;
  logic [NI-1:0] e_fire = '0;
  logic [NI-1:0] e_issue = '0;

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        m_pc[i]   <= cfg_pc(i);
        m_head[i] <= m_iss[i];
        m_arr[i]  <= m_iss[i];
      end else if (redirect) begin
        m_pc[i]   <= {rpc[31:2], 2'b00};
        m_head[i] <= m_iss[i];
        m_arr[i]  <= m_iss[i];
      end else begin
        m_head[i] <= m_head[i] + (e_fire[i] ? 1 : 0);
        if (m_arr[i] < m_iss[i] && log_cyc[i][m_arr[i] % LOGN] + cfg_lat(i) == tcyc)
          m_arr[i] <= m_arr[i] + 1;
        if (e_issue[i]) begin
          log_pc[i][m_iss[i] % LOGN]  <= m_pc[i];
          log_cyc[i][m_iss[i] % LOGN] <= tcyc;
          m_iss[i] <= m_iss[i] + 1;
          m_pc[i]  <= m_pc[i] + 32'd4;
        end
      end
    end
    tcyc <= tcyc + 1;
  end

  task automatic check(input string nm, input int inst, input logic [31:0] got,
                       input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s inst%0d cyc%0d: got %h, want %h", nm, inst, cyc, got, want);
    end
  endtask

  // Single compare process: model predictions every cycle, then fixed checkpoints
  always @(negedge clk) begin
    int          cnt, inf;
    logic        dv, fire, iss;
    logic [31:0] hpc;
    for (int i = 0; i < NI; i++) begin
      cnt  = m_arr[i] - m_head[i];
      inf  = m_iss[i] - m_arr[i];
      dv   = !rst && !redirect && (cnt != 0);
      fire = dv && rdy;
      iss  = !rst && !redirect && ((cnt + inf - (fire ? 1 : 0)) < cfg_depth(i));
      e_fire[i]  = fire;
      e_issue[i] = iss;
      check("ireq", i, 32'(o_ireq[i]), 32'(iss));
      check("deq_valid", i, 32'(o_dv[i]), 32'(dv));
      if (!rst) begin
        check("iaddr", i, 32'(o_iaddr[i]), m_pc[i] >> 2);
        check("count", i, o_count[i], 32'(cnt));
        if (dv) begin
          hpc = log_pc[i][m_head[i] % LOGN];
          check("deq_instr", i, o_instr[i], hpc);
          check("deq_pcadd4", i, o_pc4[i], hpc + 32'd4);
        end
      end
    end
    if (!rst && o_dv[0] && rdy)
      $display("deq inst0 cyc=%0d instr=%h pcadd4=%h", cyc, o_instr[0], o_pc4[0]);

    // Reset and fill, DEPTH 4 / MEM_LAT 1 / RESET_PC 0x100
    if (cyc == 0) begin
      check("lit_ireq_c0", 0, 32'(o_ireq[0]), 32'd1);
      check("lit_iaddr_c0", 0, 32'(o_iaddr[0]), 32'h40);
      check("lit_dv_c0", 0, 32'(o_dv[0]), 32'd0);
    end
    if (cyc == 1) begin
      check("lit_iaddr_c1", 0, 32'(o_iaddr[0]), 32'h41);
      check("lit_dv_c1", 0, 32'(o_dv[0]), 32'd0);
    end
    if (cyc >= 2 && cyc <= 5) begin
      check("lit_fill_dv", 0, 32'(o_dv[0]), 32'd1);
      check("lit_fill_instr", 0, o_instr[0], 32'h100 + 32'(4 * (cyc - 2)));
      check("lit_fill_pc4", 0, o_pc4[0], 32'h104 + 32'(4 * (cyc - 2)));
    end
    // PC wrap from 0xFFFF_FFF8
    if (cyc == 0) check("lit_wrap_a0", 3, 32'(o_iaddr[3]), 32'h3FFF_FFFE);
    if (cyc == 1) check("lit_wrap_a1", 3, 32'(o_iaddr[3]), 32'h3FFF_FFFF);
    if (cyc == 2) check("lit_wrap_a2", 3, 32'(o_iaddr[3]), 32'h0);
    if (cyc == 3) begin
      check("lit_wrap_instr", 3, o_instr[3], 32'hFFFF_FFFC);
      check("lit_wrap_pc4", 3, o_pc4[3], 32'h0);
    end
    // Redirect at cycle 6 with three responses in flight, MEM_LAT 3
    if (cyc == 6) check("lit_redir_dv", 2, 32'(o_dv[2]), 32'd0);
    if (cyc == 7) begin
      check("lit_redir_count", 2, o_count[2], 32'd0);
      check("lit_redir_iaddr", 2, 32'(o_iaddr[2]), 32'h800);
      check("lit_redir_ireq", 2, 32'(o_ireq[2]), 32'd1);
    end
    if (cyc == 10) check("lit_redir_dv10", 2, 32'(o_dv[2]), 32'd0);
    if (cyc == 11) begin
      check("lit_redir_dv11", 2, 32'(o_dv[2]), 32'd1);
      check("lit_redir_instr", 2, o_instr[2], 32'h2000);
    end
    // Backpressure after redirect to 0x4000, MEM_LAT 2
    if (cyc >= 21 && cyc <= 30 && o_ireq[1]) ireq_pulses++;
    if (cyc == 30) begin
      check("lit_bp_pulses", 1, 32'(ireq_pulses), 32'd4);
      check("lit_bp_count", 1, o_count[1], 32'd4);
    end
    if (cyc == 31) check("lit_bp_first", 1, o_instr[1], 32'h4000);
    // One-cycle reset at cycle 110
    if (cyc == 110) begin
      check("lit_rst_ireq", 2, 32'(o_ireq[2]), 32'd0);
      check("lit_rst_dv", 2, 32'(o_dv[2]), 32'd0);
    end
    if (cyc == 111) begin
      check("lit_rst_iaddr", 2, 32'(o_iaddr[2]), 32'h0);
      check("lit_rst_count", 2, o_count[2], 32'd0);
      check("lit_rst_ireq1", 2, 32'(o_ireq[2]), 32'd1);
    end
    if (cyc == 113) check("lit_rst_first0", 0, o_instr[0], 32'h100);
    if (cyc == 114) check("lit_rst_stale", 2, 32'(o_dv[2]), 32'd0);
    if (cyc == 115) begin
      check("lit_rst_dv2", 2, 32'(o_dv[2]), 32'd1);
      check("lit_rst_pc4", 2, o_pc4[2], 32'h4);
    end
    // Redirect to 0xFFFF_FFF2 at cycle 150
    if (cyc == 151) check("lit_r2_iaddr", 0, 32'(o_iaddr[0]), 32'h3FFF_FFFC);
    if (cyc == 156) begin
      check("lit_r2_instr", 0, o_instr[0], 32'hFFFF_FFFC);
      check("lit_r2_pc4", 0, o_pc4[0], 32'h0);
    end
  end

  task automatic step(input logic r, input logic rd, input logic [31:0] rp, input logic ry);
    rst      = r;
    redirect = rd;
    rpc      = rp;
    rdy      = ry;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Directed script: fill, redirect, backpressure, ready pattern, mid reset, redirect near wrap
  initial begin
    logic        r, rd, ry;
    logic [31:0] rp;
    logic [63:0] pat;
    pat      = 64'hF0C3_A53C_0F99_E17B;
    rst      = 1'b1;
    redirect = 1'b0;
    rpc      = 32'h0;
    rdy      = 1'b0;
    cyc      = -3;
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k <= 200; k++) begin
      r  = 1'b0;
      rd = 1'b0;
      rp = 32'h0;
      ry = 1'b1;
      if (k == 6)  begin rd = 1'b1; rp = 32'h0000_2003; end
      if (k == 20) begin rd = 1'b1; rp = 32'h0000_4000; end
      if (k >= 21 && k <= 30) ry = 1'b0;
      if (k >= 46 && k <= 99) ry = pat[k - 46];
      if (k == 110) r = 1'b1;
      if (k == 150) begin rd = 1'b1; rp = 32'hFFFF_FFF2; end
      step(r, rd, rp, ry);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
